odd_counter: RTL and testbench

Free-running odd-number counter producing the sequence 1, 3, 5, … up to the largest odd value representable in `WIDTH` bits, then wrapping. It also supports down-counting, synchronous load and count enable. It serves as a simple stimulus/sequence generator and timing-reference block in the design. The output LSB is always 1.

---
 rtl/odd_counter_pkg.sv | 13 +
 rtl/odd_counter_next.sv | 44 ++++
 rtl/odd_counter.sv | 44 ++++
 tb/tb_odd_counter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/odd_counter_pkg.sv
// Shared constants and helpers for the odd-number counter.
// Feature macro: ODD_COUNTER_SATURATE_EN (saturate at the terminal values instead of wrapping).
package odd_counter_pkg;

    parameter int unsigned ODD_COUNTER_DEFAULT_WIDTH = 4;
    parameter int unsigned ODD_COUNT_MIN             = 1;

    // All-ones value for a given width; this is also the largest odd number it can hold.
    function automatic logic [31:0] odd_count_max(input int unsigned width);
        return 32'hFFFF_FFFF >> (32 - width);
    endfunction

endpackage

// File: rtl/odd_counter_next.sv
// Combinational next-value and terminal-count logic for odd_counter.
// Feature macro: ODD_COUNTER_SATURATE_EN holds at MAX/MIN instead of wrapping around.
module odd_counter_next
    import odd_counter_pkg::*;
#(
    parameter int unsigned WIDTH = ODD_COUNTER_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX  = WIDTH'(odd_count_max(WIDTH));
    localparam logic [WIDTH-1:0] MIN  = WIDTH'(ODD_COUNT_MIN);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(2);

    logic at_terminal;

    always_comb begin
        count_next  = count;
        wrap        = 1'b0;
        at_terminal = up ? (count == MAX) : (count == MIN);

        if (load) begin
            // Forcing the LSB keeps the output odd whatever is loaded.
            count_next = load_val | MIN;
        end else if (en) begin
            wrap = at_terminal;
`ifdef ODD_COUNTER_SATURATE_EN
            if (!at_terminal) begin
                count_next = up ? count + STEP : count - STEP;
            end
`else
            // Modulo arithmetic wraps MAX+2 to 1 and 1-2 to MAX on its own.
            count_next = up ? count + STEP : count - STEP;
`endif
        end
    end

endmodule

// File: rtl/odd_counter.sv
// Odd-number counter (1, 3, 5, ... MAX) with load, enable and direction control.
// Feature macro: ODD_COUNTER_SATURATE_EN selects saturation instead of wrap-around.
module odd_counter
    import odd_counter_pkg::*;
#(
    parameter int unsigned WIDTH = ODD_COUNTER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_next;
    logic             next_wrap;

    odd_counter_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count      (count),
        .en         (en),
        .up         (up),
        .load       (load),
        .load_val   (load_val),
        .count_next (count_next),
        .wrap       (next_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= WIDTH'(ODD_COUNT_MIN);
        end else begin
            count <= count_next;
        end
    end

    // No step can happen while reset is held, so wrap is suppressed.
    assign wrap = next_wrap & ~reset;

endmodule

// File: tb/tb_odd_counter.sv
// Self-checking bench for odd_counter (WIDTH=4): directed table, corner sequences, random vs model.
// Honours ODD_COUNTER_SATURATE_EN when the design is built with it.
module tb_odd_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] count;
    logic         wrap;

    int total = 0;
    int bad   = 0;
    int m;

    typedef struct {
        bit           en;
        bit           up;
        bit           ld;
        logic [W-1:0] lv;
        bit           exp_wrap;
        logic [W-1:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    odd_counter #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model in plain integer arithmetic.
    function automatic int model_next(input int c, input bit e, input bit u, input bit ld,
                                      input int lv);
        if (ld) return lv | 1;
        if (!e) return c;
`ifdef ODD_COUNTER_SATURATE_EN
        if (u) return (c + 2 > MAXV) ? MAXV : c + 2;
        return (c - 2 < 1) ? 1 : c - 2;
`else
        if (u) return (c + 2) % (MAXV + 1);
        return (c - 2 + MAXV + 1) % (MAXV + 1);
`endif
    endfunction

    function automatic bit model_wrap(input int c, input bit e, input bit u, input bit ld);
        return e && !ld && (u ? (c == MAXV) : (c == 1));
    endfunction

    // Drive one cycle's inputs, check wrap before the edge and count after it.
    task automatic apply(input bit e, input bit u, input bit ld, input int lv,
                         input bit exp_wrap, input int exp_count);
        en       = e;
        up       = u;
        load     = ld;
        load_val = W'(lv);
        #1;
        check("wrap", int'(wrap), int'(exp_wrap));
        @(posedge clk);
        #1;
        check("count", int'(count), exp_count);
        check("count_lsb", int'(count[0]), 1);
    endtask

    task automatic add(input bit e, input bit u, input bit ld, input int lv,
                       input bit w, input int c);
        vec_t v;
        v.en        = e;
        v.up        = u;
        v.ld        = ld;
        v.lv        = W'(lv);
        v.exp_wrap  = w;
        v.exp_count = W'(c);
        vecs.push_back(v);
    endtask

    initial begin
`ifdef ODD_COUNTER_SATURATE_EN
        add(0, 0, 1, 12, 0, 13);
        add(1, 1, 0, 0,  0, 15);
        add(1, 1, 0, 0,  1, 15);
        add(1, 1, 0, 0,  1, 15);
        add(1, 0, 0, 0,  0, 13);
        add(0, 0, 1, 2,  0, 3);
        add(1, 0, 0, 0,  0, 1);
        add(1, 0, 0, 0,  1, 1);
        add(1, 0, 0, 0,  1, 1);
        add(1, 1, 1, 4,  0, 5);
`else
        add(1, 1, 0, 0, 0, 3);
        add(1, 1, 0, 0, 0, 5);
        add(1, 1, 0, 0, 0, 7);
        add(1, 1, 0, 0, 0, 9);
        add(1, 1, 0, 0, 0, 11);
        add(1, 1, 0, 0, 0, 13);
        add(1, 1, 0, 0, 0, 15);
        add(1, 1, 0, 0, 1, 1);
        add(1, 1, 0, 0, 0, 3);
        add(1, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 15);
        add(1, 0, 0, 0, 0, 13);
        add(0, 0, 1, 8, 0, 9);
        add(1, 1, 1, 6, 0, 7);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 7);
        add(0, 0, 1, 14, 0, 15);
        add(1, 1, 1, 4,  0, 5);
`endif

        reset    = 1'b1;
        en       = 1'b0;
        up       = 1'b1;
        load     = 1'b0;
        load_val = '0;
        #12;
        check("reset_count", int'(count), 1);
        check("reset_wrap", int'(wrap), 0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].en, vecs[i].up, vecs[i].ld, int'(vecs[i].lv),
                  vecs[i].exp_wrap, int'(vecs[i].exp_count));
        end

        // Asynchronous reset in the middle of a cycle at count=11.
        apply(0, 1, 1, 10, 0, 11);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", int'(count), 1);
        en   = 1'b1;
        up   = 1'b0;
        load = 1'b0;
        #1;
        check("wrap_in_reset", int'(wrap), 0);
        load     = 1'b1;
        load_val = W'(8);
        @(posedge clk);
        #1;
        check("reset_over_load", int'(count), 1);
        reset = 1'b0;
        apply(1, 1, 0, 0, 0, 3);
        m = 3;

        for (int i = 0; i < 400; i++) begin
            bit e, u, ld;
            int lv;
            if ($urandom_range(0, 19) == 0) begin
                #2;
                reset = 1'b1;
                #1;
                check("rand_async_reset", int'(count), 1);
                reset = 1'b0;
                m = 1;
            end
            e  = ($urandom_range(0, 3) != 0);
            u  = $urandom_range(0, 1) == 1;
            ld = ($urandom_range(0, 7) == 0);
            lv = int'($urandom_range(0, MAXV));
            apply(e, u, ld, lv, model_wrap(m, e, u, ld), model_next(m, e, u, ld, lv));
            m = model_next(m, e, u, ld, lv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
